// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multicycle RISC-V control FSM with ALU and immediate decoders
module multicycle_control_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic [3:0] state,
    output logic       illegal
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    state_t     state_q;
    state_t     state_d;
    state_t     dec_state;
    logic [1:0] alu_op;
    logic       branch;
    logic       pc_update;
    logic       ir_write_raw;
    logic       mem_write_raw;
    logic       reg_write_raw;
    logic       op_supported;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    assign state = state_q;

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_JAL:      state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        op_supported = 1'b0;
        case (op)
            OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL: op_supported = 1'b1;
            default:                                  op_supported = 1'b0;
        endcase
    end

    // Reset decodes as FETCH so the datapath muxes are steady; write enables are gated below.
    assign dec_state = reset ? S_FETCH : state_q;

    always_comb begin
        AdrSrc        = 1'b0;
        ir_write_raw  = 1'b0;
        mem_write_raw = 1'b0;
        reg_write_raw = 1'b0;
        ResultSrc     = 2'b00;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        alu_op        = 2'b00;
        branch        = 1'b0;
        pc_update     = 1'b0;
        case (dec_state)
            S_FETCH: begin
                ir_write_raw = 1'b1;
                ALUSrcB      = 2'b10;
                ResultSrc    = 2'b10;
                pc_update    = 1'b1;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc     = 2'b01;
                reg_write_raw = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc        = 1'b1;
                mem_write_raw = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b10;
            end
            S_EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = 2'b10;
            end
            S_ALUWB: reg_write_raw = 1'b1;
            S_BEQ: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b01;
                branch  = 1'b1;
            end
            S_JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
            end
            default: ;
        endcase
    end

    assign PCWrite  = ~reset & (pc_update | (branch & zero));
    assign IRWrite  = ~reset & ir_write_raw;
    assign MemWrite = ~reset & mem_write_raw;
    assign RegWrite = ~reset & reg_write_raw;
    assign illegal  = ~reset & (state_q == S_DECODE) & ~op_supported;

    always_comb begin
        ALUControl = 3'b000;
        case (alu_op)
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    always_comb begin
        ImmSrc = 2'b00;
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - self-checking bench for multicycle_control_fsm
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;
    logic       PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] state;

    int n_checks = 0;
    int n_fail = 0;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BEQ = 7'b1100011;
    localparam logic [6:0] JAL = 7'b1101111;

    typedef struct packed {
        logic [3:0] state;
        logic       PCWrite;
        logic       AdrSrc;
        logic       IRWrite;
        logic       MemWrite;
        logic       RegWrite;
        logic [1:0] ResultSrc;
        logic [1:0] ALUSrcA;
        logic [1:0] ALUSrcB;
        logic [1:0] ImmSrc;
        logic [2:0] ALUControl;
        logic       illegal;
    } obs_t;

    typedef struct packed {
        logic       adr;
        logic       ir;
        logic       mw;
        logic       rw;
        logic [1:0] rs;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [1:0] aluop;
        logic       br;
        logic       pcu;
    } ctl_t;

    typedef int iq_t[$];

    ctl_t ctl [0:15];

    multicycle_control_fsm dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl), .state(state), .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic logic supported(input logic [6:0] o);
        return (o == LW) || (o == SW) || (o == RT) || (o == IT) || (o == BEQ) || (o == JAL);
    endfunction

    // Instruction walk as a list of visited states, FETCH first.
    function automatic iq_t path_of(input logic [6:0] o);
        iq_t p;
        p = '{0, 1};
        if (o == LW)       p = {p, 2, 3, 4};
        else if (o == SW)  p = {p, 2, 5};
        else if (o == RT)  p = {p, 6, 8};
        else if (o == IT)  p = {p, 7, 8};
        else if (o == JAL) p = {p, 10, 8};
        else if (o == BEQ) p = {p, 9};
        return p;
    endfunction

    function automatic obs_t model(input int st, input logic [6:0] o, input logic [2:0] f3,
                                   input logic f7, input logic z, input logic r);
        ctl_t c;
        obs_t e;
        c = r ? ctl[0] : ctl[st];
        e.state    = st[3:0];
        e.AdrSrc   = c.adr;
        e.IRWrite  = c.ir & !r;
        e.MemWrite = c.mw & !r;
        e.RegWrite = c.rw & !r;
        e.ResultSrc = c.rs;
        e.ALUSrcA  = c.sa;
        e.ALUSrcB  = c.sb;
        e.PCWrite  = !r && (c.pcu || (c.br && z));
        e.ImmSrc   = (o == SW) ? 2'b01 : (o == BEQ) ? 2'b10 : (o == JAL) ? 2'b11 : 2'b00;
        e.illegal  = !r && (st == 1) && !supported(o);
        if (c.aluop == 2'b01) e.ALUControl = 3'b001;
        else if (c.aluop == 2'b10) begin
            if (f3 == 3'b000)      e.ALUControl = (o[5] && f7) ? 3'b001 : 3'b000;
            else if (f3 == 3'b010) e.ALUControl = 3'b101;
            else if (f3 == 3'b110) e.ALUControl = 3'b011;
            else if (f3 == 3'b111) e.ALUControl = 3'b010;
            else                   e.ALUControl = 3'b000;
        end else e.ALUControl = 3'b000;
        return e;
    endfunction

    task automatic cycle(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                         input logic z, input logic r, output obs_t ob);
        @(negedge clk);
        op = o; funct3 = f3; funct7b5 = f7; zero = z; reset = r;
        #1;
        ob = '{state, PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal};
    endtask

    task automatic test_reset();
        obs_t ob, e;
        for (int i = 0; i < 2; i++) begin
            cycle(7'h00, 3'd0, 1'b0, 1'b1, 1'b1, ob);
            e = model(0, 7'h00, 3'd0, 1'b0, 1'b1, 1'b1);
            n_checks++;
            if (ob !== e) begin
                n_fail++;
                $display("FAIL reset[%0d]: got %h expected %h", i, ob, e);
            end
        end
    endtask

    task automatic test_lw();
        obs_t ob, e;
        iq_t p;
        p = path_of(LW);
        foreach (p[i]) begin
            cycle(LW, 3'b010, 1'b0, 1'b0, 1'b0, ob);
            e = model(p[i], LW, 3'b010, 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (ob !== e) begin
                n_fail++;
                $display("FAIL lw step %0d: got %h expected %h", i, ob, e);
            end
        end
    endtask

    task automatic test_alu_ops();
        obs_t ob, e;
        iq_t p;
        logic [6:0] o;
        logic f7;
        for (int k = 0; k < 18; k++) begin
            o  = (k % 2 == 0) ? RT : IT;
            f7 = (k < 4) ? 1'b1 : k[2];
            p  = path_of(o);
            foreach (p[i]) begin
                cycle(o, 3'(k / 2), f7, 1'b0, 1'b0, ob);
                e = model(p[i], o, 3'(k / 2), f7, 1'b0, 1'b0);
                n_checks++;
                if (ob !== e) begin
                    n_fail++;
                    $display("FAIL alu op=%b f3=%0d f7=%b step %0d: got %h expected %h",
                             o, k / 2, f7, i, ob, e);
                end
            end
        end
    endtask

    task automatic test_beq();
        obs_t ob, e;
        iq_t p;
        p = path_of(BEQ);
        for (int k = 0; k < 2; k++) begin
            foreach (p[i]) begin
                cycle(BEQ, 3'd0, 1'b0, k[0] ^ 1'b1, 1'b0, ob);
                e = model(p[i], BEQ, 3'd0, 1'b0, k[0] ^ 1'b1, 1'b0);
                n_checks++;
                if (ob !== e) begin
                    n_fail++;
                    $display("FAIL beq zero=%b step %0d: got %h expected %h", k[0] ^ 1'b1, i, ob, e);
                end
            end
        end
    endtask

    task automatic test_illegal();
        obs_t ob, e;
        iq_t p;
        p = path_of(7'b1111111);
        for (int k = 0; k < 2; k++) begin
            foreach (p[i]) begin
                cycle(7'b1111111, 3'd0, 1'b0, 1'b1, 1'b0, ob);
                e = model(p[i], 7'b1111111, 3'd0, 1'b0, 1'b1, 1'b0);
                n_checks++;
                if (ob !== e) begin
                    n_fail++;
                    $display("FAIL illegal[%0d] step %0d: got %h expected %h", k, i, ob, e);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        obs_t ob, e;
        iq_t p;
        p = path_of(SW);
        foreach (p[i]) begin
            cycle(SW, 3'd0, 1'b0, 1'b0, (p[i] == 5), ob);
            e = model(p[i], SW, 3'd0, 1'b0, 1'b0, (p[i] == 5));
            n_checks++;
            if (ob !== e) begin
                n_fail++;
                $display("FAIL reset_mid step %0d: got %h expected %h", i, ob, e);
            end
        end
    endtask

    task automatic test_jal();
        obs_t ob, e;
        iq_t p;
        p = path_of(JAL);
        foreach (p[i]) begin
            cycle(JAL, 3'd5, 1'b1, 1'b0, 1'b0, ob);
            e = model(p[i], JAL, 3'd5, 1'b1, 1'b0, 1'b0);
            n_checks++;
            if (ob !== e) begin
                n_fail++;
                $display("FAIL jal step %0d: got %h expected %h", i, ob, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t ob, e;
        iq_t p;
        logic [6:0] ops [0:5];
        logic [6:0] o;
        logic [2:0] f3;
        logic f7, z, r;
        ops = '{LW, SW, RT, IT, BEQ, JAL};
        for (int n = 0; n < 80; n++) begin
            int sel;
            sel = int'($urandom_range(0, 7));
            o  = (sel < 6) ? ops[sel] : 7'($urandom);
            f3 = 3'($urandom);
            f7 = 1'($urandom);
            p  = path_of(o);
            foreach (p[i]) begin
                z = 1'($urandom);
                r = ($urandom_range(0, 24) == 0);
                cycle(o, f3, f7, z, r, ob);
                e = model(p[i], o, f3, f7, z, r);
                n_checks++;
                if (ob !== e) begin
                    n_fail++;
                    $display("FAIL random instr %0d op=%b step %0d rst=%b: got %h expected %h",
                             n, o, i, r, ob, e);
                end
                if (r) break;
            end
        end
    endtask

    initial begin
        for (int s = 0; s < 16; s++) ctl[s] = '0;
        //          adr   ir    mw    rw    rs     sa     sb     aluop  br    pcu
        ctl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b1};
        ctl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0};
        ctl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0};
        ctl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
        ctl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
        ctl[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
        ctl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0, 1'b0};
        ctl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b10, 1'b0, 1'b0};
        ctl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
        ctl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01, 1'b1, 1'b0};
        ctl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0, 1'b1};

        test_reset();
        test_lw();
        test_alu_ops();
        test_beq();
        test_illegal();
        test_reset_mid();
        test_jal();
        test_back_to_back();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
MULTICYCLE_CONTROL_FSM -- requirements
Module: multicycle_control_fsm

Interface
REQ-001 SHALL have no parameters; all widths are fixed as listed below.
REQ-002 SHALL have port clk, input, 1 bit: clock; all state updates occur on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port op, input, 7 bits: instruction opcode field.
REQ-005 SHALL have port funct3, input, 3 bits: instruction funct3 field.
REQ-006 SHALL have port funct7b5, input, 1 bit: instruction bit 30.
REQ-007 SHALL have port zero, input, 1 bit: ALU zero flag.
REQ-008 SHALL have output PCWrite, 1 bit: PC register enable.
REQ-009 SHALL have outputs AdrSrc (1 bit), IRWrite (1 bit), MemWrite (1 bit) and RegWrite (1 bit).
REQ-010 SHALL have 2-bit outputs ResultSrc, ALUSrcA, ALUSrcB and ImmSrc, and a 3-bit output ALUControl.
REQ-011 SHALL have output state, 4 bits: current FSM state, for debug.
REQ-012 SHALL have output illegal, 1 bit: unsupported-opcode pulse.

Function
REQ-013 SHALL use these state encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10; codes 11-15 SHALL go to FETCH on the next edge.
REQ-014 SHALL use these opcodes: lw=0000011, sw=0100011, R=0110011, I=0010011, beq=1100011, jal=1101111.
REQ-015 SHALL follow these transitions: FETCH->DECODE; DECODE->MEMADR (lw, sw), EXECUTER (R), EXECUTEI (I), JAL (jal), BEQ (beq), otherwise FETCH.
REQ-016 SHALL continue: MEMADR->MEMREAD (lw) or MEMWRITE (otherwise); MEMREAD->MEMWB; MEMWB, MEMWRITE, ALUWB, BEQ->FETCH; EXECUTER, EXECUTEI, JAL->ALUWB.
REQ-017 SHALL produce Moore outputs from state only, except ALUControl, PCWrite and illegal; any field not listed for a state SHALL be 0.
REQ-018 In FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1.
REQ-019 In DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
REQ-020 In MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
REQ-021 In MEMREAD: AdrSrc=1, ResultSrc=00. In MEMWB: ResultSrc=01, RegWrite=1. In MEMWRITE: AdrSrc=1, MemWrite=1.
REQ-022 In EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. In EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. In ALUWB: ResultSrc=00, RegWrite=1.
REQ-023 In BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. In JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
REQ-024 PCWrite SHALL equal PCUpdate OR (Branch AND zero), combinationally.
REQ-025 ALUControl SHALL be: ALUOp=00 -> 000 (add); 01 -> 001 (sub); 10 -> decode funct3 per REQ-026; 11 -> 000.
REQ-026 funct3 decode: 000 -> 001 if op[5]=1 and funct7b5=1, else 000; 010 -> 101; 110 -> 011; 111 -> 010; others -> 000.
REQ-027 ImmSrc SHALL decode combinationally from op in every state: lw/I -> 00, sw -> 01, beq -> 10, jal -> 11, others -> 00.
REQ-028 illegal SHALL be 1 for exactly the DECODE cycle when op is unsupported, and 0 otherwise.
REQ-029 Instruction latency in cycles, FETCH through return to FETCH: lw=5, sw=4, R=4, I=4, jal=4, beq=3 (taken or not).

Reset
REQ-030 While reset=1, the state register SHALL load FETCH on each rising edge.
REQ-031 While reset=1, PCWrite, IRWrite, MemWrite, RegWrite and illegal SHALL be forced to 0; all other outputs follow FETCH decode.
REQ-032 Reset asserted in any state mid-instruction SHALL abandon that instruction, with no further write enables asserted.
REQ-033 The first cycle after reset deasserts SHALL be FETCH, with IRWrite=1 and PCWrite=1.

Verification
REQ-034 Bench: lw (op=0000011) from reset -> states 0,1,2,3,4,0; RegWrite=1 only in state 4; AdrSrc=1 in state 3.
REQ-035 Bench: sub (op=0110011, funct3=000, funct7b5=1) -> ALUControl=001 in EXECUTER; addi with funct7b5=1 (op=0010011) -> ALUControl=000 in EXECUTEI.
REQ-036 Bench: beq with zero=1 -> PCWrite=1 in BEQ; with zero=0 -> PCWrite=0; both return to FETCH after 3 cycles.
REQ-037 Bench: op=1111111 -> illegal=1 for one cycle in DECODE, next state FETCH, no RegWrite or MemWrite asserted.
REQ-038 Bench: reset asserted in MEMWRITE -> MemWrite=0 that cycle; state=0 after the edge.
REQ-039 Bench: jal -> states 0,1,10,8,0; PCWrite=1 in JAL; RegWrite=1 in ALUWB; ImmSrc=11 throughout.
